sc_rr_slave_responder: RTL and testbench

//  Slave-side responder for the sc_rr crossbar req/ack bus; answers o_req_sl_*/o_addr_sl_*/o_cmd_sl_*/o_wdata_sl_*.

---
 rtl/sc_rr_slave_responder_pkg.sv | 31 +++
 rtl/sc_rr_wait_gen.sv | 55 +++++
 rtl/sc_rr_slave_responder.sv | 126 ++++++++++++
 tb/tb_sc_rr_slave_responder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/sc_rr_slave_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sc_rr_slave_responder_pkg
// Purpose  : Shared types and constants for the sc_rr slave responder.
//            LFSR items exist only when SC_RR_SLAVE_RAND_WAIT_EN is defined.
// Revision : 1.0
// ============================================================================
package sc_rr_slave_responder_pkg;

    typedef enum logic [1:0] {
        SC_RR_ST_IDLE = 2'd0,
        SC_RR_ST_WAIT = 2'd1,
        SC_RR_ST_ACK  = 2'd2
    } sc_rr_state_t;

    localparam logic        SC_RR_CMD_RD    = 1'b0;
    localparam logic        SC_RR_CMD_WR    = 1'b1;
    localparam logic [31:0] SC_RR_ERR_RDATA = 32'hDEAD_BEEF;

`ifdef SC_RR_SLAVE_RAND_WAIT_EN
    localparam logic [15:0] SC_RR_LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] SC_RR_LFSR_TAPS = 16'hB400;

    function automatic logic sc_rr_lfsr_fb(input logic [15:0] state);
        return ^(state & SC_RR_LFSR_TAPS);
    endfunction
`endif

endpackage
`default_nettype wire

// File: rtl/sc_rr_wait_gen.sv
`default_nettype none
// ============================================================================
// Module   : sc_rr_wait_gen
// Purpose  : Wait-state counter for the slave responder; optional LFSR-drawn
//            wait count when SC_RR_SLAVE_RAND_WAIT_EN is defined.
// Revision : 1.0
// ============================================================================
module sc_rr_wait_gen
    import sc_rr_slave_responder_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    input  logic i_dec,
    output logic o_wait_none,
    output logic o_cnt_zero
);

    logic [3:0] w_wait;
    logic [3:0] r_cnt;

`ifdef SC_RR_SLAVE_RAND_WAIT_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lfsr <= SC_RR_LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[14:0], sc_rr_lfsr_fb(r_lfsr)};
        end
    end

    assign w_wait = r_lfsr[3:0];
`else
    assign w_wait = 4'(WAIT_CYCLES);
`endif

    // A zero wait count bypasses the WAIT state entirely
    assign o_wait_none = (w_wait == 4'd0);
    assign o_cnt_zero  = (r_cnt == 4'd0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= 4'd0;
        end else if (i_load && !o_wait_none) begin
            r_cnt <= w_wait - 4'd1;
        end else if (i_dec && !o_cnt_zero) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sc_rr_slave_responder.sv
`default_nettype none
// ============================================================================
// Module   : sc_rr_slave_responder
// Purpose  : Register-array slave for the sc_rr crossbar with wait states and
//            a one-cycle ack. Option macro: SC_RR_SLAVE_RAND_WAIT_EN.
// Revision : 1.0
// ============================================================================
module sc_rr_slave_responder
    import sc_rr_slave_responder_pkg::*;
#(
    parameter int          DEPTH_LOG2  = 8,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic        i_cmd,
    input  logic [31:0] i_wdata,
    output logic        o_ack,
    output logic [31:0] o_rdata,
    output logic        o_busy
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    sc_rr_state_t    r_state;
    logic [31:2]     r_addr;
    logic            r_cmd;
    logic [31:0]     r_wdata;
    logic [31:0]     r_mem [DEPTH];

    logic                  w_capture;
    logic                  w_enter_ack;
    logic                  w_wait_none;
    logic                  w_cnt_zero;
    logic [31:2]           w_addr;
    logic                  w_cmd;
    logic [31:0]           w_wdata;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  w_in_range;
    logic                  w_unused_addr;

    assign w_unused_addr = ^i_addr[1:0];

    assign w_capture   = (r_state == SC_RR_ST_IDLE) && i_req;
    assign w_enter_ack = (w_capture && w_wait_none) ||
                         ((r_state == SC_RR_ST_WAIT) && w_cnt_zero);

    // With zero wait states ACK is entered on the capture edge itself,
    // so the live inputs stand in for the holding registers.
    assign w_addr  = (r_state == SC_RR_ST_IDLE) ? i_addr[31:2] : r_addr;
    assign w_cmd   = (r_state == SC_RR_ST_IDLE) ? i_cmd        : r_cmd;
    assign w_wdata = (r_state == SC_RR_ST_IDLE) ? i_wdata      : r_wdata;

    assign w_idx      = w_addr[DEPTH_LOG2+1:2];
    assign w_in_range = (w_addr[31:DEPTH_LOG2+2] == BASE_ADDR[31:DEPTH_LOG2+2]);

    sc_rr_wait_gen #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_gen (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_load      (w_capture),
        .i_dec       (r_state == SC_RR_ST_WAIT),
        .o_wait_none (w_wait_none),
        .o_cnt_zero  (w_cnt_zero)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= SC_RR_ST_IDLE;
            o_ack   <= 1'b0;
            o_rdata <= 32'd0;
            o_busy  <= 1'b0;
        end else begin
            o_ack   <= 1'b0;
            o_rdata <= 32'd0;
            case (r_state)
                SC_RR_ST_IDLE: begin
                    if (i_req) begin
                        r_addr  <= i_addr[31:2];
                        r_cmd   <= i_cmd;
                        r_wdata <= i_wdata;
                        o_busy  <= 1'b1;
                        r_state <= w_wait_none ? SC_RR_ST_ACK : SC_RR_ST_WAIT;
                    end
                end
                SC_RR_ST_WAIT: begin
                    if (w_cnt_zero) begin
                        r_state <= SC_RR_ST_ACK;
                    end
                end
                SC_RR_ST_ACK: begin
                    r_state <= SC_RR_ST_IDLE;
                    o_busy  <= 1'b0;
                end
                default: begin
                    r_state <= SC_RR_ST_IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
            if (w_enter_ack) begin
                o_ack <= 1'b1;
                if (w_cmd == SC_RR_CMD_RD) begin
                    o_rdata <= w_in_range ? r_mem[w_idx] : SC_RR_ERR_RDATA;
                end
            end
        end
    end

    // Array is never cleared; a reset on the ACK edge drops the write.
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_enter_ack && (w_cmd == SC_RR_CMD_WR) && w_in_range) begin
            r_mem[w_idx] <= w_wdata;
        end
    end

    a_req_held_in_wait: assert property (
        @(posedge i_clk) disable iff (i_rst)
        (r_state == SC_RR_ST_WAIT) |-> i_req
    );

endmodule
`default_nettype wire

// File: tb/tb_sc_rr_slave_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sc_rr_slave_responder
// Purpose  : Directed and random checks of sc_rr_slave_responder against a
//            word-array reference model.
// Revision : 1.0
// ============================================================================
module tb_sc_rr_slave_responder;

    localparam int          DEPTH_LOG2  = 8;
    localparam int          WAIT_CYCLES = 2;
    localparam logic [31:0] BASE_ADDR   = 32'h0000_0000;
`ifdef SC_RR_SLAVE_RAND_WAIT_EN
    localparam int          N_RANDOM    = 1000;
`else
    localparam int          N_RANDOM    = 200;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [31:0] addr = 32'd0;
    logic        cmd = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic        ack;
    logic [31:0] rdata;
    logic        busy;

    int     total = 0;
    int     bad   = 0;
    longint cyc   = 0;

    logic [31:0] m_mem [256];
    bit          m_vld [256];
    bit          lat_seen [17];

    sc_rr_slave_responder #(
        .DEPTH_LOG2  (DEPTH_LOG2),
        .WAIT_CYCLES (WAIT_CYCLES),
        .BASE_ADDR   (BASE_ADDR)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_req   (req),
        .i_addr  (addr),
        .i_cmd   (cmd),
        .i_wdata (wdata),
        .o_ack   (ack),
        .o_rdata (rdata),
        .o_busy  (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One bus transaction; hold keeps req high past the ack cycle
    task automatic txn(input logic c, input logic [31:0] a, input logic [31:0] d,
                       input bit hold, output logic [31:0] rd, output int lat,
                       output longint ack_at);
        @(negedge clk);
        req = 1'b1; cmd = c; addr = a; wdata = d;
        @(posedge clk);
        lat = 0; rd = 32'd0; ack_at = 0;
        for (int k = 1; k <= 40; k++) begin
            #1;
            if (ack === 1'b1) begin
                lat = k;
                break;
            end
            check("busy_before_ack", {31'd0, busy}, 32'd1);
            check("rdata_before_ack", rdata, 32'd0);
            @(posedge clk);
        end
        if (lat == 0) begin
            check("ack_timeout", {31'd0, ack}, 32'd1);
            req = 1'b0;
            return;
        end
        ack_at = cyc;
        rd = rdata;
        check("busy_in_ack", {31'd0, busy}, 32'd1);
        @(negedge clk);
        if (!hold) req = 1'b0;
        @(posedge clk);
        #1;
        check("ack_one_cycle", {31'd0, ack}, 32'd0);
        check("rdata_after_ack", rdata, 32'd0);
        check("busy_after_ack", {31'd0, busy}, 32'd0);
    endtask

    // Transaction plus reference-model bookkeeping and checks
    task automatic run(input logic c, input logic [31:0] a, input logic [31:0] d,
                       input bit hold, output longint ack_at);
        logic [31:0] rd;
        int          lat;
        bit          in_range;
        int          idx;
        txn(c, a, d, hold, rd, lat, ack_at);
        if (lat == 0) return;
`ifdef SC_RR_SLAVE_RAND_WAIT_EN
        check("latency_range", {31'd0, (lat >= 1 && lat <= 16)}, 32'd1);
        if (lat >= 1 && lat <= 16) lat_seen[lat] = 1'b1;
`else
        check("latency", lat, WAIT_CYCLES + 1);
`endif
        in_range = (a[31:10] == BASE_ADDR[31:10]);
        idx      = int'(a[9:2]);
        if (c == 1'b1) begin
            if (in_range) begin
                m_mem[idx] = d;
                m_vld[idx] = 1'b1;
            end
        end else if (!in_range) begin
            check("rdata_out_of_range", rd, 32'hDEAD_BEEF);
        end else if (m_vld[idx]) begin
            check("rdata", rd, m_mem[idx]);
        end
    endtask

    initial begin
        longint t_a, t_b, t_x;
        int     distinct;
        logic   rc;
        logic [31:0] ra;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_ack", {31'd0, ack}, 32'd0);
        check("reset_rdata", rdata, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic write then read
        run(1'b1, 32'h10, 32'hA5A5_0001, 1'b0, t_x);
        run(1'b0, 32'h10, 32'd0, 1'b0, t_x);

        // Back-to-back write/read with req held
        run(1'b1, 32'h20, 32'h1234_5678, 1'b1, t_a);
        run(1'b0, 32'h20, 32'd0, 1'b0, t_b);
`ifndef SC_RR_SLAVE_RAND_WAIT_EN
        check("b2b_ack_spacing", 32'(t_b - t_a), WAIT_CYCLES + 2);
`endif

        // Out-of-range access
        run(1'b1, 32'h0, 32'h0BAD_F00D, 1'b0, t_x);
        run(1'b0, BASE_ADDR + 32'h400, 32'd0, 1'b0, t_x);
        run(1'b1, BASE_ADDR + 32'h400, 32'hFFFF_FFFF, 1'b0, t_x);
        run(1'b0, 32'h0, 32'd0, 1'b0, t_x);

        // Reset during the wait of a write
        run(1'b1, 32'h30, 32'h3030_3030, 1'b0, t_x);
        @(negedge clk);
        req = 1'b1; cmd = 1'b1; addr = 32'h30; wdata = 32'hFFFF_0000;
        @(posedge clk);
        #1;
        if (ack === 1'b1) begin
            // Zero drawn wait count: the write completed before reset could act
            m_mem[12] = 32'hFFFF_0000;
            @(negedge clk);
            req = 1'b0;
            @(posedge clk);
        end else begin
            @(negedge clk);
            rst = 1'b1; req = 1'b0;
            @(posedge clk);
            #1;
            check("rst_mid_busy", {31'd0, busy}, 32'd0);
            check("rst_mid_ack", {31'd0, ack}, 32'd0);
            @(negedge clk);
            rst = 1'b0;
            repeat (4) begin
                @(posedge clk);
                #1;
                check("no_ack_after_rst", {31'd0, ack}, 32'd0);
            end
        end
        run(1'b0, 32'h30, 32'd0, 1'b0, t_x);

        // Random traffic against the model
        for (int i = 0; i < 32; i++) begin
            run(1'b1, 32'(i * 4), $urandom, 1'b0, t_x);
        end
        for (int i = 0; i < N_RANDOM; i++) begin
            rc = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) begin
                ra = $urandom | 32'h0000_0400;
            end else begin
                ra = {22'd0, 5'($urandom_range(0, 31)), 3'd0} | 32'($urandom_range(0, 3));
                ra[2] = 1'($urandom_range(0, 1));
            end
            run(rc, ra, $urandom, 1'($urandom_range(0, 1)), t_x);
        end

`ifdef SC_RR_SLAVE_RAND_WAIT_EN
        distinct = 0;
        for (int l = 1; l <= 16; l++) begin
            if (lat_seen[l]) distinct++;
        end
        check("distinct_latencies_ge8", {31'd0, (distinct >= 8)}, 32'd1);
`else
        distinct = 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
